// File: rtl/tmr_recovery_sequencer_pkg.sv
// Shared types and encodings for the TMR rollback recovery sequencer.
// Holds the FSM state enum, RV32 load/nop encodings and instruction field positions.
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_INJ_RD,
        ST_INJ_RS1,
        ST_INJ_RS2,
        ST_WB,
        ST_RESUME,
        ST_FATAL
    } state_t;

    localparam logic [6:0]  OPC_LOAD = 7'b0000011;
    localparam logic [2:0]  F3_LW    = 3'b010;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    // lw rX,0(rX): reloads rX from the recovery data copy.
    function automatic logic [31:0] lw_self(input logic [4:0] r);
        return {12'h000, r, F3_LW, r, OPC_LOAD};
    endfunction

endpackage

// File: rtl/rollback_inject_gen.sv
// Builds the register-reload word for the current inject state and flags
// which inject states are redundant (x0 or a register already reloaded).
module rollback_inject_gen
    import tmr_pkg::*;
(
    input  state_t      state,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] inject_word,
    output logic        skip_rd,
    output logic        skip_rs1,
    output logic        skip_rs2
);

    always_comb begin
        skip_rd  = (rd == 5'd0);
        skip_rs1 = (rs1 == 5'd0) || (rs1 == rd);
        skip_rs2 = (rs2 == 5'd0) || (rs2 == rd) || (rs2 == rs1);

        inject_word = NOP_WORD;
        case (state)
            ST_INJ_RD:  inject_word = lw_self(rd);
            ST_INJ_RS1: inject_word = lw_self(rs1);
            ST_INJ_RS2: inject_word = lw_self(rs2);
            default:    inject_word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/tmr_recovery_sequencer.sv
// Rollback recovery sequencer for the TMR cores: freeze, drain, reload the
// faulting instruction's registers, wait for writeback, resume at the rollback PC.
module tmr_recovery_sequencer
    import tmr_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned WB_CYCLES    = 4,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       voter_state,
    input  logic [31:0]      pc_voted,
    input  logic [31:0]      pc_rollback,
    input  logic [31:0]      instr_rollback,
    output logic [31:0]      fetch_word,
    output logic             core_hold,
    output logic             recovery_mode,
    output logic             recovery_mem_sel,
    output logic             data_recovery_sel,
    output logic             recovery_done,
    output logic             fatal,
    output logic [CNT_W-1:0] fault_count
);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  retry_cnt;
    logic        fatal_q;
    logic [31:0] cap_pc;
    logic [4:0]  cap_rd, cap_rs1, cap_rs2;
    logic [31:0] inject_word;
    logic        skip_rd, skip_rs1, skip_rs2;
    logic        fault;
    state_t      first_inj, after_rd, after_rs1;

    assign fault = (voter_state == 3'b000);

    rollback_inject_gen u_inject_gen (
        .state       (state),
        .rd          (cap_rd),
        .rs1         (cap_rs1),
        .rs2         (cap_rs2),
        .inject_word (inject_word),
        .skip_rd     (skip_rd),
        .skip_rs1    (skip_rs1),
        .skip_rs2    (skip_rs2)
    );

    // Redundant inject states are jumped over so they cost no cycles.
    always_comb begin
        after_rs1 = skip_rs2 ? ST_WB : ST_INJ_RS2;
        after_rd  = skip_rs1 ? after_rs1 : ST_INJ_RS1;
        first_inj = skip_rd ? after_rd : ST_INJ_RD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            retry_cnt   <= '0;
            fatal_q     <= 1'b0;
            fault_count <= '0;
            cap_pc      <= '0;
            cap_rd      <= '0;
            cap_rs1     <= '0;
            cap_rs2     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fault) begin
                        cap_pc  <= pc_rollback;
                        cap_rd  <= instr_rollback[RD_LSB  +: 5];
                        cap_rs1 <= instr_rollback[RS1_LSB +: 5];
                        cap_rs2 <= instr_rollback[RS2_LSB +: 5];
                        if (fault_count != '1)
                            fault_count <= fault_count + 1'b1;
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        retry_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == 8'(DRAIN_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= first_inj;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_INJ_RD:  state <= after_rd;
                ST_INJ_RS1: state <= after_rs1;
                ST_INJ_RS2: state <= ST_WB;
                ST_WB: begin
                    if (cnt == 8'(WB_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_RESUME;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESUME: begin
                    if (fault) begin
                        retry_cnt <= retry_cnt + 8'd1;
                        if (retry_cnt + 8'd1 == 8'(MAX_RETRIES)) begin
                            fatal_q <= 1'b1;
                            state   <= ST_FATAL;
                        end else begin
                            cap_pc  <= pc_rollback;
                            cap_rd  <= instr_rollback[RD_LSB  +: 5];
                            cap_rs1 <= instr_rollback[RS1_LSB +: 5];
                            cap_rs2 <= instr_rollback[RS2_LSB +: 5];
                            if (fault_count != '1)
                                fault_count <= fault_count + 1'b1;
                            cnt   <= '0;
                            state <= ST_DRAIN;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_FATAL: state <= ST_FATAL;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_word = NOP_WORD;
        case (state)
            ST_IDLE:    fetch_word = pc_voted;
            ST_INJ_RD,
            ST_INJ_RS1,
            ST_INJ_RS2: fetch_word = inject_word;
            ST_RESUME:  fetch_word = cap_pc;
            default:    fetch_word = NOP_WORD;
        endcase
    end

    assign core_hold         = (state == ST_DRAIN) || (state == ST_WB) || (state == ST_FATAL);
    assign recovery_mode     = (state != ST_IDLE);
    assign recovery_mem_sel  = recovery_mode;
    assign data_recovery_sel = (state == ST_INJ_RD) || (state == ST_INJ_RS1) ||
                               (state == ST_INJ_RS2) || (state == ST_WB);
    assign recovery_done     = (state == ST_RESUME);
    assign fatal             = fatal_q;

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Scoreboard bench for tmr_recovery_sequencer: expected inject/resume words are
// queued at fault time and popped by a monitor whenever the DUT presents one.
module tb_tmr_recovery_sequencer;

    typedef struct packed {
        logic [31:0] word;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  voter_state = 3'b111;
    logic [31:0] pc_voted = 32'hDEAD_BEEF;
    logic [31:0] pc_rollback = '0;
    logic [31:0] instr_rollback = 32'h0000_0013;
    logic [31:0] fetch_word;
    logic        core_hold, recovery_mode, recovery_mem_sel, data_recovery_sel;
    logic        recovery_done, fatal;
    logic [7:0]  fault_count;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    tmr_recovery_sequencer #(
        .DRAIN_CYCLES (3),
        .WB_CYCLES    (4),
        .MAX_RETRIES  (3),
        .CNT_W        (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .voter_state       (voter_state),
        .pc_voted          (pc_voted),
        .pc_rollback       (pc_rollback),
        .instr_rollback    (instr_rollback),
        .fetch_word        (fetch_word),
        .core_hold         (core_hold),
        .recovery_mode     (recovery_mode),
        .recovery_mem_sel  (recovery_mem_sel),
        .data_recovery_sel (data_recovery_sel),
        .recovery_done     (recovery_done),
        .fatal             (fatal),
        .fault_count       (fault_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] word, input logic done);
        exp_t e;
        e.word = word;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Monitor: inject cycles and resume pulses are the observable transactions.
    always @(negedge clk) begin
        if (rst_n && ((data_recovery_sel && !core_hold) || recovery_done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", fetch_word);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_word", fetch_word, e.word);
                check("sb_done", {31'd0, recovery_done}, {31'd0, e.done});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        voter_state = 3'b111;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents a fault for exactly one sampling edge.
    task automatic fault(input logic [31:0] instr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        voter_state = 3'b000;
        instr_rollback = instr;
        pc_rollback = pc;
        @(posedge clk);
        #1 voter_state = 3'b111;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (recovery_mode && n < 200);
        if (recovery_mode) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_hold", {31'd0, core_hold}, 32'd0);
        check("rst_mode", {30'd0, recovery_mode, recovery_mem_sel}, 32'd0);
        check("rst_fatal", {31'd0, fatal}, 32'd0);
        check("rst_count", {24'd0, fault_count}, 32'd0);
        check("idle_fetch", fetch_word, 32'hDEAD_BEEF);

        // add x2,x1,x2: rd=x2, rs1=x1, rs2=x2 (duplicate, skipped)
        push(32'h0001_2103, 1'b0);
        push(32'h0000_a083, 1'b0);
        push(32'h0000_0040, 1'b1);
        fault(32'h0020_8133, 32'h0000_0040);
        #4;
        check("lat_hold", {31'd0, core_hold}, 32'd1);
        check("drain_nop", fetch_word, 32'h0000_0013);
        repeat (3) @(posedge clk);
        #1;
        check("lat_inject", {30'd0, data_recovery_sel, core_hold}, 32'd2);
        wait_idle("t1");
        check("t1_count", {24'd0, fault_count}, 32'd1);

        // Partial disagreement is masked by the voter.
        @(posedge clk);
        #1 voter_state = 3'b110;
        @(posedge clk);
        #1 voter_state = 3'b111;
        @(negedge clk);
        check("partial_nofault", {31'd0, recovery_mode}, 32'd0);

        // All fields x0: straight from DRAIN to WB.
        push(32'h0000_0080, 1'b1);
        fault(32'h0000_0013, 32'h0000_0080);
        wait_idle("t2");

        // Fault toggling during WB is ignored; captured PC frozen.
        push(32'h0001_2103, 1'b0);
        push(32'h0000_a083, 1'b0);
        push(32'h0000_0100, 1'b1);
        fault(32'h0020_8133, 32'h0000_0100);
        pc_rollback = 32'h0000_0999;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (data_recovery_sel && core_hold) break;
        end
        voter_state = 3'b000;
        @(negedge clk);
        voter_state = 3'b111;
        wait_idle("t3");
        check("t3_count", {24'd0, fault_count}, 32'd3);

        // Asynchronous reset during INJ_RS1.
        push(32'h0001_2103, 1'b0);
        push(32'h0000_a083, 1'b0);
        fault(32'h0020_8133, 32'h0000_0040);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (data_recovery_sel && !core_hold && fetch_word == 32'h0000_a083) break;
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_hold", {31'd0, core_hold}, 32'd0);
        check("arst_mode", {29'd0, recovery_mode, recovery_mem_sel, data_recovery_sel}, 32'd0);
        check("arst_done", {31'd0, recovery_done}, 32'd0);
        check("arst_count", {24'd0, fault_count}, 32'd0);
        check("arst_fetch", fetch_word, 32'hDEAD_BEEF);
        pc_voted = 32'h0000_1234;
        #1;
        check("arst_follow", fetch_word, 32'h0000_1234);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Persistent fault through three RESUMEs ends in FATAL.
        push(32'h0000_0200, 1'b1);
        push(32'h0000_0200, 1'b1);
        push(32'h0000_0200, 1'b1);
        @(posedge clk);
        #1;
        voter_state = 3'b000;
        instr_rollback = 32'h0000_0013;
        pc_rollback = 32'h0000_0200;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fatal) break;
        end
        check("fatal_set", {31'd0, fatal}, 32'd1);
        check("fatal_count", {24'd0, fault_count}, 32'd3);
        voter_state = 3'b111;
        repeat (5) @(negedge clk);
        check("fatal_sticky", {30'd0, fatal, core_hold}, 32'd3);
        check("fatal_fetch", fetch_word, 32'h0000_0013);
        check("fatal_mode", {31'd0, recovery_mode}, 32'd1);
        do_reset();
        @(negedge clk);
        check("fatal_cleared", {31'd0, fatal}, 32'd0);

        // Saturation of fault_count.
        for (int i = 1; i <= 256; i++) begin
            push(32'(i * 4), 1'b1);
            fault(32'h0000_0013, 32'(i * 4));
            wait_idle("sat");
            if (i == 254) check("sat_254", {24'd0, fault_count}, 32'h0000_00FE);
            if (i == 255) check("sat_255", {24'd0, fault_count}, 32'h0000_00FF);
        end
        check("sat_256", {24'd0, fault_count}, 32'h0000_00FF);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
